// File: rtl/dlfloat_accum.sv
// Streaming DLfloat16 dot-product accumulator: one sum per in_last-terminated packet.
// Optional sticky ovf/unf status outputs are built when DLFLOAT_ACC_STATUS_EN is defined.
module dlfloat_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DLFLOAT_ACC_STATUS_EN
  ,
  output logic             ovf,
  output logic             unf
`endif
);

  // state   | meaning
  // ACCEPT  | waiting for a term, in_ready=1
  // ALIGN   | order acc/term by magnitude, shift the smaller significand
  // ADD     | add or subtract aligned significands
  // NORM    | normalize, saturate/flush, write acc
  // OUT     | sum presented until out_ready
  typedef enum logic [2:0] {
    S_ACCEPT,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_OUT
  } state_t;

  state_t r_state, w_state_nxt;

  logic [15:0]      r_term;
  logic             r_last;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [12:0]      r_big;
  logic [12:0]      r_small;
  logic [5:0]       r_exp;
  logic             r_sign;
  logic             r_sub;
  logic [13:0]      r_sum;
`ifdef DLFLOAT_ACC_STATUS_EN
  logic             r_ovf;
  logic             r_unf;
`endif

  function automatic logic [3:0] f_lzc(input logic [12:0] v);
    logic [3:0] n;
    n = 4'd13;
    for (int i = 0; i < 13; i++) begin
      if (v[i]) n = 4'(12 - i);
    end
    return n;
  endfunction

  function automatic logic [8:0] f_frac(input logic [12:0] v, input logic [3:0] sh);
    logic [12:0] t;
    t = v << sh;
    return t[11:3];
  endfunction

  // ALIGN datapath: an exponent of 0 means zero regardless of fraction
  logic [5:0]  w_t_exp, w_a_exp, w_d;
  logic [12:0] w_t_sig, w_a_sig, w_big_sig, w_small_sig, w_small_sh;
  logic        w_term_big, w_big_sign, w_small_sign;
  logic [5:0]  w_big_exp, w_small_exp;

  always_comb begin
    w_t_exp      = r_term[14:9];
    w_a_exp      = r_acc[14:9];
    w_t_sig      = (w_t_exp == 6'd0) ? 13'd0 : {1'b1, r_term[8:0], 3'b000};
    w_a_sig      = (w_a_exp == 6'd0) ? 13'd0 : {1'b1, r_acc[8:0], 3'b000};
    w_term_big   = {w_t_exp, w_t_sig} > {w_a_exp, w_a_sig};
    w_big_sig    = w_term_big ? w_t_sig : w_a_sig;
    w_small_sig  = w_term_big ? w_a_sig : w_t_sig;
    w_big_exp    = w_term_big ? w_t_exp : w_a_exp;
    w_small_exp  = w_term_big ? w_a_exp : w_t_exp;
    w_big_sign   = w_term_big ? r_term[15] : r_acc[15];
    w_small_sign = w_term_big ? r_acc[15] : r_term[15];
    w_d          = w_big_exp - w_small_exp;
    w_small_sh   = (w_d >= 6'd13) ? 13'd0 : (w_small_sig >> w_d);
  end

  // NORM datapath: exponent kept signed and wide so saturation/flush are plain compares
  logic [3:0]        w_lz;
  logic signed [7:0] w_exp_n;
  logic [8:0]        w_frac;
  logic              w_zero, w_sat, w_flush;
  logic [15:0]       w_res;

  always_comb begin
    w_lz    = f_lzc(r_sum[12:0]);
    w_zero  = (r_sum == 14'd0);
    w_exp_n = 8'sd0;
    w_frac  = 9'd0;
    if (r_sum[13]) begin
      w_exp_n = $signed({2'b00, r_exp}) + 8'sd1;
      w_frac  = r_sum[12:4];
    end else begin
      w_exp_n = $signed({2'b00, r_exp}) - $signed({4'b0000, w_lz});
      w_frac  = f_frac(r_sum[12:0], w_lz);
    end
    w_sat   = !w_zero && (w_exp_n > 8'sd62);
    w_flush = !w_zero && (w_exp_n < 8'sd1);
    if (w_zero || w_flush) w_res = 16'h0000;
    else if (w_sat)        w_res = {r_sign, 6'd62, 9'h1FF};
    else                   w_res = {r_sign, w_exp_n[5:0], w_frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ACCEPT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_ALIGN;
      end
      S_ALIGN: w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = r_last ? S_OUT : S_ACCEPT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_ACCEPT;
      end
      default: w_state_nxt = S_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_term  <= 16'h0000;
      r_last  <= 1'b0;
      r_acc   <= 16'h0000;
      r_cnt   <= '0;
      r_big   <= 13'd0;
      r_small <= 13'd0;
      r_exp   <= 6'd0;
      r_sign  <= 1'b0;
      r_sub   <= 1'b0;
      r_sum   <= 14'd0;
`ifdef DLFLOAT_ACC_STATUS_EN
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_ACCEPT: begin
          if (in_valid) begin
            r_term <= in_data;
            r_last <= in_last;
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ALIGN: begin
          r_big   <= w_big_sig;
          r_small <= w_small_sh;
          r_exp   <= w_big_exp;
          r_sign  <= w_big_sign;
          r_sub   <= w_big_sign ^ w_small_sign;
        end
        S_ADD: begin
          if (r_sub) r_sum <= {1'b0, r_big} - {1'b0, r_small};
          else       r_sum <= {1'b0, r_big} + {1'b0, r_small};
        end
        S_NORM: begin
          r_acc <= w_res;
`ifdef DLFLOAT_ACC_STATUS_EN
          r_ovf <= r_ovf | w_sat;
          r_unf <= r_unf | w_flush;
`endif
        end
        S_OUT: begin
          if (out_ready) begin
            r_acc <= 16'h0000;
            r_cnt <= '0;
`ifdef DLFLOAT_ACC_STATUS_EN
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_acc;
  assign out_cnt  = r_cnt;
`ifdef DLFLOAT_ACC_STATUS_EN
  assign ovf = r_ovf;
  assign unf = r_unf;
`endif

endmodule

// File: tb/tb_dlfloat_accum.sv
// Directed scoreboard bench for dlfloat_accum: packets, boundaries, backpressure, resets.
module tb_dlfloat_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_cnt;
`ifdef DLFLOAT_ACC_STATUS_EN
  logic        ovf, unf;
`endif

  dlfloat_accum #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_valid(out_valid), .out_ready(out_ready)
`ifdef DLFLOAT_ACC_STATUS_EN
    , .ovf(ovf), .unf(unf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  c;
    logic        o;
    logic        u;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int acc_cyc = 0;
  int hs_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_res(input logic [15:0] d, input logic [7:0] c, input logic o, input logic u);
    exp_t e;
    e.d = d; e.c = c; e.o = o; e.u = u;
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    in_data = d; in_last = l; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", in_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (out_valid !== 1'b1 && n < 40);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_lat"}, cyc - acc_cyc, 3);
    e = sb.pop_front();
    check({tag, "_data"}, out_data, e.d);
    check({tag, "_cnt"}, out_cnt, e.c);
`ifdef DLFLOAT_ACC_STATUS_EN
    check({tag, "_ovf"}, ovf, e.o);
    check({tag, "_unf"}, unf, e.u);
`endif
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 0);
    check({tag, "_rdy"}, in_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // async reset while a result is being held
    send(16'h3E00, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 16'h0000);
    check("rst_cnt", out_cnt, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    expect_res(16'h4100, 8'd3, 1'b0, 1'b0);
    send(16'h3E00, 1'b0); send(16'h3E00, 1'b0); send(16'h3E00, 1'b1);
    collect("sum3");

    expect_res(16'h0000, 8'd2, 1'b0, 1'b0);
    send(16'h3F00, 1'b0); send(16'hBF00, 1'b1);
    collect("cancel");

    expect_res(16'h7DFF, 8'd2, 1'b1, 1'b0);
    send(16'h7DFF, 1'b0); send(16'h7DFF, 1'b1);
    collect("sat");

    expect_res(16'h0000, 8'd1, 1'b0, 1'b0);
    send(16'h0000, 1'b1);
    collect("zero1");

    expect_res(16'h3E00, 8'd2, 1'b0, 1'b0);
    send(16'h4000, 1'b0); send(16'hBE00, 1'b1);
    collect("lshift");

    expect_res(16'h4040, 8'd2, 1'b0, 1'b0);
    send(16'h4000, 1'b0); send(16'h3A00, 1'b1);
    collect("align3");

    expect_res(16'h0000, 8'd2, 1'b0, 1'b1);
    send(16'h0300, 1'b0); send(16'h8200, 1'b1);
    collect("flush");

    // backpressure with a pending upstream term
    send(16'h4400, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_valid", out_valid, 1);
    in_data = 16'h3E00; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data", out_data, 16'h4400);
      check("bp_cnt", out_cnt, 1);
      check("bp_inrdy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    out_ready = 1'b0;
    check("bp_drop", out_valid, 0);
    check("bp_rdy_after", in_ready, 1);
    @(posedge clk);
    #1;
    check("bp_accept_edge", in_ready, 0);
    check("bp_accept_cnt", out_cnt, 1);
    acc_cyc = cyc;
    in_valid = 1'b0; in_last = 1'b0;
    expect_res(16'h3E00, 8'd1, 1'b0, 1'b0);
    collect("bp_next");

    // reset during ALIGN discards the partial packet
    send(16'h4000, 1'b0);
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    check("midrst_ready", in_ready, 1);
    check("midrst_cnt", out_cnt, 0);
    expect_res(16'h3E00, 8'd1, 1'b0, 1'b0);
    send(16'h3E00, 1'b1);
    collect("midrst");

    // term counter saturates at 255
    expect_res(16'h0000, 8'd255, 1'b0, 1'b0);
    for (int i = 0; i < 259; i++) send(16'h0000, 1'b0);
    send(16'h0000, 1'b1);
    collect("cntsat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dlfloat_accum.md
# dlfloat_accum

Streaming DLfloat16 accumulator that consumes the product stream of the DLfloat16 multiplier and reduces it to one dot-product sum per input packet. Terms arrive on a valid/ready handshake with a `last` marker. Each term passes through a multi-cycle align/add/normalize FSM. The finished sum and its term count are presented on an output valid/ready handshake to the next stage, such as write-back or activation.

## Interface

Parameters:
- CNT_W, 8, width of the term counter; the count saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state and outputs immediately.
- in_data  in  16  DLfloat16 term: [15] sign, [14:9] exponent (bias 31), [8:0] fraction.
- in_valid  in  1  term present.
- in_last  in  1  term is the final one of the packet; sampled with in_data.
- in_ready  out  1  block accepts a term this cycle.
- out_data  out  16  accumulated DLfloat16 sum.
- out_cnt  out  CNT_W  number of terms accepted in the packet.
- out_valid  out  1  sum is valid; held until out_ready.
- out_ready  in  1  downstream accepts the sum.

## Operation

- FSM states: ACCEPT, ALIGN, ADD, NORM, OUT. Reset state is ACCEPT with acc=16'h0000 and cnt=0.
- ACCEPT:
  - in_ready=1.
  - On in_valid, latch the term and in_last, increment cnt (saturating), and go to ALIGN.
- ALIGN:
  - Any operand with exponent 0 is zero, whatever its fraction.
  - Form 13-bit significands {1,frac,3'b000}.
  - Order the operands by magnitude: exponent first, then fraction.
  - Right-shift the smaller operand by the exponent difference d. Bits shifted out are dropped; d≥13 gives 0.
- ADD:
  - Same signs: add magnitudes. Different signs: subtract the smaller from the larger.
  - Result is 14 bits. Sign is that of the larger-magnitude operand.
- NORM:
  - If bit13 is set: shift right 1 and add 1 to the exponent.
  - Otherwise: shift left until bit12 is set, decrementing the exponent per shift.
  - Fraction = bits[11:3], truncated with no rounding.
  - Zero magnitude gives +0 (16'h0000).
  - Exponent >62 saturates to {s,6'd62,9'h1FF}.
  - Exponent <1 flushes to 16'h0000.
  - Write the result to acc. Next state is OUT if the latched last=1, else ACCEPT.
- OUT:
  - out_valid=1, out_data=acc, out_cnt=cnt.
  - On out_ready, go to ACCEPT and clear acc and cnt to 0.
- Any input exponent value 1..63 is treated as numeric. Only results are bounded at exponent 62.

## Timing

- Reset values: in_ready=1, out_valid=0, out_data=16'h0000, out_cnt=0.
- A term is accepted at rising edge k where in_valid&&in_ready. The FSM is in ALIGN at k, ADD at k+1, NORM at k+2, and ACCEPT or OUT after edge k+3.
- Throughput is one term per 4 cycles. The next term can be accepted at edge k+4 at the earliest.
- Latency: out_valid rises 3 edges after the last term is accepted.
- in_ready=0 in ALIGN, ADD, NORM and OUT. No input is accepted while the result is held, including under backpressure.
- out_data and out_cnt are stable while out_valid=1 and out_ready=0.
- Handshake at edge j (out_valid&&out_ready): out_valid drops and in_ready rises after j. The first term of the next packet is accepted at edge j+1 at the earliest.
- in_valid while in_ready=0 is ignored. The upstream stage must hold its data.
- rst asserted mid-operation (any state) returns to ACCEPT with acc and cnt cleared. Partial results are discarded.

## Configuration

- DLFLOAT_ACC_STATUS_EN defined:
  - Adds output ports ovf and unf (1 bit each, reset 0).
  - These are sticky flags, set in NORM when saturation or flush-to-zero occurs.
  - Valid with out_valid; cleared on the output handshake and on rst.
- DLFLOAT_ACC_STATUS_EN undefined:
  - Ports and logic are absent.
  - Saturation and flush behaviour is unchanged.

## Test plan

- Reset: assert rst mid-cycle with in_valid=0 -> immediately out_valid=0, out_data=16'h0000, out_cnt=0, in_ready=1.
- Sum 3E00, 3E00, 3E00 (last on the third) -> out_data=16'h4100 (3.0), out_cnt=3, out_valid rising 3 edges after the third accept.
- Cancellation: 3F00 then BF00 (last) -> out_data=16'h0000, out_cnt=2; unf=0 with the macro defined.
- Saturation: 7DFF then 7DFF (last) -> out_data=16'h7DFF, out_cnt=2; ovf=1 with the macro defined. Single term 0000 (last) -> out_data=16'h0000, out_cnt=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0, no term accepted. Release -> the next packet's first term accepted one edge after the handshake.
- Reset mid-packet: accept 4000, assert rst during ALIGN, then send 3E00 (last) -> out_data=16'h3E00, out_cnt=1.
